// File: rtl/dly_load_seq_pkg.sv
// Shared PHY definitions for the delay-tap load sequencer.
//   DLY_WIDTH_DEF     : default tap value width
//   SETTLE_CYCLES_DEF : default number of wait cycles after the global set pulse
//   dly_state_e       : sequencer state encoding
package dly_load_seq_pkg;

    localparam int DLY_WIDTH_DEF     = 5;
    localparam int SETTLE_CYCLES_DEF = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_RDY,
        ST_LOAD,
        ST_SET,
        ST_SETTLE,
        ST_DONE
    } dly_state_e;

endpackage

// File: rtl/dly_load_seq_stage.sv
// Staging array plus dirty vector for the delay-tap load sequencer.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   we, wr_addr,   : host write port; out-of-range addresses are ignored
//   wr_data
//   rd_idx         : element currently visited by the scan
//   rd_data        : staged tap of element rd_idx
//   rd_dirty       : dirty bit of element rd_idx
//   clr, clr_idx   : clear the dirty bit of clr_idx (a same-cycle write wins)
//   dirty_any      : registered OR of all dirty bits
module dly_stage_regs
    import dly_load_seq_pkg::*;
#(
    parameter int                   NUM_DLY     = 8,
    parameter int                   ADDR_WIDTH  = 3,
    parameter int                   DLY_WIDTH   = DLY_WIDTH_DEF,
    parameter logic [DLY_WIDTH-1:0] DLY_DEFAULT = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DLY_WIDTH-1:0]  wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_idx,
    output logic [DLY_WIDTH-1:0]  rd_data,
    output logic                  rd_dirty,
    input  logic                  clr,
    input  logic [ADDR_WIDTH-1:0] clr_idx,
    output logic                  dirty_any
);

    logic [DLY_WIDTH-1:0] staging [NUM_DLY];
    logic [NUM_DLY-1:0]   dirty;
    logic [NUM_DLY-1:0]   dirty_d;

    // Clear first, then set, so a host write in the same cycle keeps the bit.
    always_comb begin
        dirty_d = dirty;
        for (int unsigned i = 0; i < NUM_DLY; i++) begin
            if (clr && clr_idx == ADDR_WIDTH'(i)) dirty_d[i] = 1'b0;
            if (we && wr_addr == ADDR_WIDTH'(i))  dirty_d[i] = 1'b1;
        end
    end

    always_comb begin
        rd_data  = '0;
        rd_dirty = 1'b0;
        for (int unsigned i = 0; i < NUM_DLY; i++) begin
            if (rd_idx == ADDR_WIDTH'(i)) begin
                rd_data  = staging[i];
                rd_dirty = dirty[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_DLY; i++) staging[i] <= DLY_DEFAULT;
            dirty     <= '1;
            dirty_any <= 1'b1;
        end else begin
            for (int unsigned i = 0; i < NUM_DLY; i++) begin
                if (we && wr_addr == ADDR_WIDTH'(i)) staging[i] <= wr_data;
            end
            dirty     <= dirty_d;
            dirty_any <= |dirty_d;
        end
    end

endmodule

// File: rtl/dly_load_seq.sv
// Delay-tap load sequencer for a bank of delay elements sharing one tap bus.
// Host writes targets into staging; on apply, each dirty element gets a
// one-hot ld strobe with its tap on 'delay', then one global 'set' pulse.
// Ports:
//   clk, rst              : divided PHY clock, asynchronous active-high reset
//   cmd_we/addr/data      : staging write
//   cmd_apply             : request to push dirty entries (collapses while busy)
//   dly_ready             : idelay_ctrl ready, synchronous to clk
//   busy, done, dirty_any : status (all registered)
//   delay, ld, set        : shared tap bus, per-element load strobe, global set
module dly_load_seq
    import dly_load_seq_pkg::*;
#(
    parameter int                   NUM_DLY       = 8,
    parameter int                   ADDR_WIDTH    = 3,
    parameter int                   DLY_WIDTH     = DLY_WIDTH_DEF,
    parameter logic [DLY_WIDTH-1:0] DLY_DEFAULT   = '0,
    parameter int                   SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_we,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DLY_WIDTH-1:0]  cmd_data,
    input  logic                  cmd_apply,
    input  logic                  dly_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  dirty_any,
    output logic [DLY_WIDTH-1:0]  delay,
    output logic [NUM_DLY-1:0]    ld,
    output logic                  set
);

    dly_state_e            state, state_d;
    logic [ADDR_WIDTH-1:0] idx, idx_d;
    logic [3:0]            cnt, cnt_d;
    logic                  loaded, loaded_d;
    logic                  pending, pending_d;
    logic [NUM_DLY-1:0]    ld_d;
    logic [DLY_WIDTH-1:0]  delay_d;
    logic                  set_d;
    logic                  done_d;
    logic                  clr;
    logic [DLY_WIDTH-1:0]  rd_data;
    logic                  rd_dirty;

    dly_stage_regs #(
        .NUM_DLY     (NUM_DLY),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .DLY_WIDTH   (DLY_WIDTH),
        .DLY_DEFAULT (DLY_DEFAULT)
    ) u_stage (
        .clk       (clk),
        .rst       (rst),
        .we        (cmd_we),
        .wr_addr   (cmd_addr),
        .wr_data   (cmd_data),
        .rd_idx    (idx),
        .rd_data   (rd_data),
        .rd_dirty  (rd_dirty),
        .clr       (clr),
        .clr_idx   (idx),
        .dirty_any (dirty_any)
    );

    always_comb begin
        state_d   = state;
        idx_d     = idx;
        cnt_d     = cnt;
        loaded_d  = loaded;
        pending_d = pending;
        ld_d      = '0;
        delay_d   = delay;
        set_d     = 1'b0;
        done_d    = 1'b0;
        clr       = 1'b0;

        if (cmd_apply && state != ST_IDLE) pending_d = 1'b1;

        case (state)
            ST_IDLE: begin
                if (cmd_apply || pending) begin
                    state_d   = ST_WAIT_RDY;
                    pending_d = 1'b0;
                end
            end
            ST_WAIT_RDY: begin
                if (dly_ready) begin
                    state_d = ST_LOAD;
                    idx_d   = '0;
                end
            end
            ST_LOAD: begin
                // A ready drop freezes the scan; idx only advances while ready.
                if (dly_ready) begin
                    if (rd_dirty) begin
                        delay_d  = rd_data;
                        ld_d     = NUM_DLY'(1) << idx;
                        clr      = 1'b1;
                        loaded_d = 1'b1;
                    end
                    if (idx == ADDR_WIDTH'(NUM_DLY - 1)) begin
                        state_d = (loaded || rd_dirty) ? ST_SET : ST_DONE;
                    end else begin
                        idx_d = idx + 1'b1;
                    end
                end
            end
            ST_SET: begin
                set_d   = 1'b1;
                cnt_d   = '0;
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt == 4'(SETTLE_CYCLES - 1)) state_d = ST_DONE;
                else                              cnt_d   = cnt + 1'b1;
            end
            ST_DONE: begin
                done_d   = 1'b1;
                loaded_d = 1'b0;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            idx     <= '0;
            cnt     <= '0;
            loaded  <= 1'b0;
            pending <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            set     <= 1'b0;
            ld      <= '0;
            delay   <= '0;
        end else begin
            state   <= state_d;
            idx     <= idx_d;
            cnt     <= cnt_d;
            loaded  <= loaded_d;
            pending <= pending_d;
            busy    <= (state != ST_IDLE);
            done    <= done_d;
            set     <= set_d;
            ld      <= ld_d;
            delay   <= delay_d;
        end
    end

endmodule

// File: tb/tb_dly_load_seq.sv
// Directed self-checking bench for dly_load_seq (NUM_DLY=8, SETTLE_CYCLES=2).
module tb_dly_load_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_we = 1'b0;
    logic [2:0] cmd_addr = '0;
    logic [4:0] cmd_data = '0;
    logic       cmd_apply = 1'b0;
    logic       dly_ready = 1'b1;
    logic       busy, done, dirty_any, set;
    logic [4:0] delay;
    logic [7:0] ld;

    int errors = 0;
    int checks = 0;

    logic [4:0] m_stage [8];
    logic [7:0] m_dirty;
    logic [4:0] m_delay;

    dly_load_seq #(
        .NUM_DLY       (8),
        .ADDR_WIDTH    (3),
        .DLY_WIDTH     (5),
        .DLY_DEFAULT   (5'd0),
        .SETTLE_CYCLES (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_we    (cmd_we),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .cmd_apply (cmd_apply),
        .dly_ready (dly_ready),
        .busy      (busy),
        .done      (done),
        .dirty_any (dirty_any),
        .delay     (delay),
        .ld        (ld),
        .set       (set)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [4:0] d);
        cmd_we = 1'b1; cmd_addr = a; cmd_data = d;
        step();
        cmd_we = 1'b0;
        m_stage[a] = d;
        m_dirty[a] = 1'b1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_stage[i] = 5'd0;
        m_dirty = 8'hFF;
        m_delay = 5'd0;
    endtask

    // Apply with dly_ready steady high; k is the number of edges after T.
    task automatic run_seq(input string name);
        logic       any;
        logic [7:0] exp_ld;
        int         len;
        any = |m_dirty;
        len = any ? 14 : 11;
        cmd_apply = 1'b1;
        step();
        cmd_apply = 1'b0;
        for (int k = 1; k <= len; k++) begin
            step();
            exp_ld = 8'h00;
            if (k >= 2 && k <= 9 && m_dirty[k-2]) begin
                exp_ld  = 8'(1) << (k - 2);
                m_delay = m_stage[k-2];
            end
            chk({name, ".ld"},    32'(ld),    32'(exp_ld));
            chk({name, ".delay"}, 32'(delay), 32'(m_delay));
            chk({name, ".set"},   32'(set),   32'(any && k == 10));
            chk({name, ".done"},  32'(done),  32'(k == (any ? 13 : 10)));
            chk({name, ".busy"},  32'(busy),  32'(k <= (any ? 13 : 10)));
        end
        m_dirty = 8'h00;
        chk({name, ".dirty_any"}, 32'(dirty_any), 32'(0));
    endtask

    initial begin
        logic [7:0] exp_ld;
        model_reset();

        // Reset state
        step(); step();
        chk("rst.busy",  32'(busy),      32'(0));
        chk("rst.done",  32'(done),      32'(0));
        chk("rst.set",   32'(set),       32'(0));
        chk("rst.ld",    32'(ld),        32'(0));
        chk("rst.delay", 32'(delay),     32'(0));
        chk("rst.dirty", 32'(dirty_any), 32'(1));
        rst = 1'b0;
        step();

        // 1: first apply loads every element with the default
        run_seq("t1");

        // 2: two sparse writes
        wr(3'd3, 5'd17);
        wr(3'd5, 5'd9);
        chk("t2.dirty_any", 32'(dirty_any), 32'(1));
        run_seq("t2");

        // 3: nothing dirty
        run_seq("t3");

        // 4: ready low at apply, raised at T+7, dropped for edges T+12..T+14
        wr(3'd1, 5'd5);
        wr(3'd4, 5'd21);
        dly_ready = 1'b0;
        cmd_apply = 1'b1;
        step();
        cmd_apply = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            dly_ready = (k >= 7 && k <= 11) || k >= 15;
            step();
            exp_ld = 8'h00;
            if (k == 9)  begin exp_ld = 8'h02; m_delay = 5'd5;  end
            if (k == 15) begin exp_ld = 8'h10; m_delay = 5'd21; end
            chk("t4.ld",    32'(ld),    32'(exp_ld));
            chk("t4.delay", 32'(delay), 32'(m_delay));
            chk("t4.set",   32'(set),   32'(k == 19));
            chk("t4.done",  32'(done),  32'(k == 22));
            chk("t4.busy",  32'(busy),  32'(k <= 22));
        end
        m_dirty = 8'h00;
        dly_ready = 1'b1;

        // 5: writes and apply while LOAD visits idx 2
        wr(3'd2, 5'd3);
        cmd_apply = 1'b1;
        step();
        cmd_apply = 1'b0;
        for (int k = 1; k <= 29; k++) begin
            cmd_we = 1'b0; cmd_apply = 1'b0;
            if (k == 4) begin cmd_we = 1'b1; cmd_addr = 3'd2; cmd_data = 5'd11; cmd_apply = 1'b1; end
            if (k == 5) begin cmd_we = 1'b1; cmd_addr = 3'd0; cmd_data = 5'd7; end
            step();
            exp_ld = 8'h00;
            if (k == 4)  begin exp_ld = 8'h04; m_delay = 5'd3;  end
            if (k == 16) begin exp_ld = 8'h01; m_delay = 5'd7;  end
            if (k == 18) begin exp_ld = 8'h04; m_delay = 5'd11; end
            chk("t5.ld",    32'(ld),    32'(exp_ld));
            chk("t5.delay", 32'(delay), 32'(m_delay));
            chk("t5.set",   32'(set),   32'(k == 10 || k == 24));
            chk("t5.done",  32'(done),  32'(k == 13 || k == 27));
            chk("t5.busy",  32'(busy),  32'((k >= 1 && k <= 13) || (k >= 15 && k <= 27)));
        end
        cmd_we = 1'b0;
        m_stage[0] = 5'd7;
        m_stage[2] = 5'd11;
        m_dirty = 8'h00;
        chk("t5.dirty_any", 32'(dirty_any), 32'(0));

        // 6: reset during SETTLE
        wr(3'd6, 5'd30);
        cmd_apply = 1'b1;
        step();
        cmd_apply = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            step();
            exp_ld = (k == 8) ? 8'h40 : 8'h00;
            chk("t6.ld",  32'(ld),  32'(exp_ld));
            chk("t6.set", 32'(set), 32'(k == 10));
        end
        #2 rst = 1'b1;
        #1;
        chk("t6.rst.busy",  32'(busy),      32'(0));
        chk("t6.rst.set",   32'(set),       32'(0));
        chk("t6.rst.ld",    32'(ld),        32'(0));
        chk("t6.rst.done",  32'(done),      32'(0));
        chk("t6.rst.delay", 32'(delay),     32'(0));
        chk("t6.rst.dirty", 32'(dirty_any), 32'(1));
        #1 rst = 1'b0;
        model_reset();
        step();
        chk("t6.idle.busy", 32'(busy), 32'(0));
        run_seq("t6.reload");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dly_load_seq.md
Name: dly_load_seq

Overview:
Sequences delay-tap updates into a bank of NUM_DLY odelay_pipe/idelay-style delay elements that share one delay bus. A host writes target taps into a staging array. On an apply command, the block loads each changed element with a per-element ld pulse, then issues one global set pulse so all new taps take effect together. Sits in the PHY, clocked by the same divided clock as the delay pipes, and gated by the idelay_ctrl ready flag.

Parameters:
NUM_DLY, 8, number of delay elements sharing the bus (2..16)
ADDR_WIDTH, 3, element index width; must satisfy 2**ADDR_WIDTH >= NUM_DLY
DLY_WIDTH, 5, tap value width
DLY_DEFAULT, 0, staging value for every element after reset
SETTLE_CYCLES, 2, wait cycles after set before done (1..15)

Ports:
clk  in  1  delay-pipe clock (divided clock domain)
rst  in  1  asynchronous reset, active-high
cmd_we  in  1  write cmd_data into staging[cmd_addr]
cmd_addr  in  ADDR_WIDTH  element index
cmd_data  in  DLY_WIDTH  tap value
cmd_apply  in  1  one-cycle request to push dirty entries to hardware
dly_ready  in  1  idelay_ctrl rdy (already synchronous to clk)
busy  out  1  apply sequence in progress
done  out  1  one-cycle pulse at end of apply
dirty_any  out  1  OR of all dirty bits
delay  out  DLY_WIDTH  shared tap bus to all delay elements
ld  out  NUM_DLY  one-hot load strobe; ld[i] captures delay into element i
set  out  1  global pulse transferring loaded taps into the primitives

Behaviour:
- Reset (async, rst=1): busy, done, set, ld, delay = 0; state IDLE; staging[*]=DLY_DEFAULT; dirty[*]=1 so the first apply programs every element; apply_pending=0.
- All outputs are registered. cmd_addr >= NUM_DLY: write ignored.
- Staging writes are accepted in every state. A write sets dirty[cmd_addr].
- FSM states:
  - IDLE: on cmd_apply or apply_pending, go to WAIT_RDY and clear apply_pending.
  - WAIT_RDY: hold until dly_ready=1, then go to LOAD with idx=0.
  - LOAD: one element per cycle, idx 0..NUM_DLY-1.
    - If dirty[idx]: drive delay<=staging[idx], ld<=onehot(idx), clear dirty[idx], set loaded_flag.
    - Otherwise ld<=0 and delay holds.
    - If dly_ready=0 in LOAD: pause (idx held, ld=0) and resume when it returns.
    - After idx=NUM_DLY-1: go to SET if loaded_flag, else go to DONE.
  - SET: set=1 for exactly one cycle, ld=0, then SETTLE.
  - SETTLE: count SETTLE_CYCLES cycles, then DONE.
  - DONE: done=1 for one cycle, clear loaded_flag, return to IDLE.
- busy=1 in every state except IDLE.
- Timing, with cmd_apply sampled at edge T and dly_ready steady high: WAIT_RDY lasts one cycle. ld[i] is driven from edge T+2+i. set is driven from edge T+2+NUM_DLY. done is driven from edge T+3+NUM_DLY+SETTLE_CYCLES.
- cmd_apply while busy: sets apply_pending; a second sequence starts right after DONE. Multiple requests collapse into one.
- Write to element idx in the same cycle LOAD visits idx: ld uses the old staging value, and dirty stays 1 (set wins over clear), so the new value goes out on the next apply.
- Write to an element already passed in the current scan: it stays dirty for the next apply.
- Apply with no dirty bits: no ld and no set; done follows LOAD.
- ld is never multi-hot. set never overlaps ld.
- rst mid-sequence: immediate return to reset values, with no partial set pulse.

Decomposition:
- Shared PHY package: DLY_WIDTH default, the state encoding enum (IDLE, WAIT_RDY, LOAD, SET, SETTLE, DONE), and the SETTLE_CYCLES default.
- Staging array plus dirty vector as one sub-module, dly_stage_regs. It provides a write port, a read port at idx, and a clear-dirty port with set-wins-over-clear priority.
- FSM and counters stay in dly_load_seq.

Test Plan:
1. Reset, dly_ready=1, cmd_apply at T (NUM_DLY=8, SETTLE=2) -> ld[0..7] one-hot at edges T+2..T+9, all delay=0, set at T+10, done at T+13, dirty_any=0 afterwards.
2. Write staging[3]=17, staging[5]=9, then apply -> only ld[3] (delay=17) and ld[5] (delay=9) pulse, at edges T+5 and T+7; one set pulse.
3. Apply with nothing dirty -> no ld, no set; done at T+10; busy high T+1..T+10.
4. dly_ready low at apply, raised 6 cycles later; dropped again for 3 cycles while idx=4 -> sequence waits, ld[4] is delayed by 3 cycles, no ld during the drop.
5. During LOAD at idx=2, write staging[2]=11 and staging[0]=7, and pulse cmd_apply -> current ld[2] carries the old value. A second sequence follows done and loads elements 0 (delay=7) and 2 (delay=11) only.
6. Assert rst during SETTLE -> busy, set, ld, done =0 immediately; dirty_any=1; the next apply reloads all 8 elements with DLY_DEFAULT.
